// File: rtl/phase_gen.sv
// phase_gen: multicycle sequencer emitting one-hot f/d/e/m/w phases with fetch and data-memory waits.
// Define PHASE_GEN_STEP_EN to add step_mode/step ports and a PAUSE state after each W.
module phase_gen #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        run,
  input  logic        halt_req,
  input  logic        mem_op,
  input  logic        mem_ack,
`ifdef PHASE_GEN_STEP_EN
  input  logic        step_mode,
  input  logic        step,
`endif
  output logic        mem_req,
  output logic [4:0]  phase,
  output logic        busy,
  output logic        err,
  output logic [31:0] instr_cnt
);

`ifdef PHASE_GEN_STEP_EN
  typedef enum logic [3:0] {
    S_IDLE, S_FREQ, S_F, S_D, S_E, S_MREQ, S_M, S_W, S_HALT, S_ERR, S_PAUSE
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_FREQ, S_F, S_D, S_E, S_MREQ, S_M, S_W, S_HALT, S_ERR
  } state_t;
`endif

  state_t          state, nxt;
  logic [TO_W-1:0] wcnt;
  logic            hpend;
  logic            to_hit;

  assign to_hit = (wcnt == TO_W'(TIMEOUT));

  function automatic logic is_busy(input state_t s);
    return !(s inside {S_IDLE, S_HALT, S_ERR});
  endfunction

  function automatic logic [4:0] phase_of(input state_t s);
    case (s)
      S_F:     return 5'b00001;
      S_D:     return 5'b00010;
      S_E:     return 5'b00100;
      S_M:     return 5'b01000;
      S_W:     return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  // ack wins over timeout, so an ack in the last allowed wait cycle is still accepted
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (run) nxt = S_FREQ;
      S_FREQ: begin
        if (mem_ack)     nxt = S_F;
        else if (to_hit) nxt = S_ERR;
      end
      S_F:    nxt = S_D;
      S_D:    nxt = S_E;
      S_E:    nxt = mem_op ? S_MREQ : S_M;
      S_MREQ: begin
        if (mem_ack)     nxt = S_M;
        else if (to_hit) nxt = S_ERR;
      end
      S_M:    nxt = S_W;
      S_W: begin
        if (hpend || halt_req) nxt = S_HALT;
`ifdef PHASE_GEN_STEP_EN
        else if (step_mode)    nxt = S_PAUSE;
`endif
        else                   nxt = S_FREQ;
      end
      S_HALT: if (run && !halt_req) nxt = S_FREQ;
      S_ERR:  nxt = S_ERR;
`ifdef PHASE_GEN_STEP_EN
      S_PAUSE: if (step) nxt = S_FREQ;
`endif
      default: nxt = S_IDLE;
    endcase
  end

  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      phase     <= '0;
      mem_req   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      instr_cnt <= '0;
      hpend     <= 1'b0;
      wcnt      <= '0;
    end else begin
      state   <= nxt;
      phase   <= phase_of(nxt);
      mem_req <= (nxt == S_FREQ) || (nxt == S_MREQ);
      busy    <= is_busy(nxt);
      if (nxt == S_ERR) err <= 1'b1;
      if (state == S_W) instr_cnt <= instr_cnt + 32'd1;
      if (nxt == S_HALT)                  hpend <= 1'b0;
      else if (is_busy(state) && halt_req) hpend <= 1'b1;
      if (nxt != state)                                wcnt <= '0;
      else if (state == S_FREQ || state == S_MREQ)     wcnt <= wcnt + 1'b1;
    end
  end

endmodule

// File: doc/phase_gen.md
Name: phase_gen

Overview:
- Multicycle sequencer that produces the one-hot 5-bit phase vector consumed by the PC, register file, ALU and memory stages.
- Phase bits: f=0, d=1, e=2, m=3, w=4.
- Inserts fetch and data-memory wait states through a req/ack handshake.
- Counts retired instructions, honours halt requests at instruction boundaries, and flags memory timeouts.

Parameters:
- TIMEOUT, 255: maximum wait cycles in a memory-request state before entering ERR (1..2^TO_W-1).
- TO_W, 8: width of the wait-cycle counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- n_rst  in  1  asynchronous active-low reset.
- run  in  1  level; starts or resumes sequencing from IDLE or HALT.
- halt_req  in  1  pulse or level; requests a stop after the current instruction's w phase.
- mem_op  in  1  decoded current instruction needs data memory; sampled in the e phase.
- mem_ack  in  1  memory completion for the outstanding mem_req.
- mem_req  out  1  memory request, asserted in FREQ and MREQ.
- phase  out  5  one-hot phase, or all-zero in non-phase states.
- busy  out  1  high in every state except IDLE, HALT and ERR.
- err  out  1  memory timeout occurred; sticky.
- instr_cnt  out  32  retired instruction count.

Behaviour:
- Reset (n_rst=0, asynchronous):
  - state=IDLE; phase=0; mem_req=0; busy=0; err=0; instr_cnt=0.
  - Halt-pending flag and wait counter cleared.
  - Reset mid-instruction abandons the instruction with no partial phase afterwards.
- States and outputs:
  - IDLE, HALT, ERR: phase=0.
  - FREQ, MREQ: phase=0, mem_req=1.
  - F: phase=00001.
  - D: phase=00010.
  - E: phase=00100.
  - M: phase=01000.
  - W: phase=10000.
- Transitions:
  - IDLE -> FREQ when run=1.
  - FREQ -> F on the cycle after mem_ack=1 is sampled. Ack in the first FREQ cycle is legal (zero wait).
  - F -> D -> E, unconditional, one cycle each.
  - E -> MREQ if mem_op=1, else E -> M. M is still a one-cycle m phase with no memory access.
  - MREQ -> M on the cycle after mem_ack=1.
  - M -> W.
  - W -> HALT if halt pending (including halt_req high in the W cycle itself), else W -> FREQ.
  - HALT -> FREQ when run=1 and halt_req=0; otherwise stay in HALT.
  - FREQ/MREQ -> ERR when the wait counter reaches TIMEOUT without ack.
  - ERR is terminal until reset; err=1 from the cycle ERR is entered.
- Phase invariant: each phase bit is high for exactly one clock per instruction. The PC increments exactly once per fetch regardless of wait length.
- Wait counter:
  - Cleared on entry to FREQ or MREQ.
  - Increments each cycle in the state without ack.
  - Compared against TIMEOUT before incrementing.
- mem_ack outside FREQ/MREQ is ignored.
- mem_req deasserts in the cycle after ack is sampled.
- Halt pending:
  - Set by halt_req=1 in any busy state.
  - Cleared when HALT is entered.
  - halt_req in IDLE/HALT is ignored; run has no effect while busy.
- instr_cnt:
  - Increments by 1 on each W cycle.
  - Wraps from 0xFFFFFFFF to 0.
  - Holds in HALT/ERR; cleared only by reset.
- Minimum instruction time: 6 cycles (FREQ+F+D+E+M+W) with zero-wait fetch and mem_op=0. A zero-wait load/store takes 7.

Optional Feature:
- Macro: PHASE_GEN_STEP_EN.
- Defined:
  - Adds input ports step_mode (1 bit) and step (1 bit).
  - With step_mode=1, W goes to a PAUSE state (phase=0, busy=1) instead of FREQ.
  - PAUSE -> FREQ on step=1.
  - halt_req pending at W still takes priority (W -> HALT).
  - step_mode=0 behaves exactly as without the macro.
- Undefined: ports and PAUSE state absent.

Test Plan:
- Reset then run=1, mem_ack tied 1, mem_op=0 -> phase sequence 0,1,2,4,8,16 repeating every 6 cycles; instr_cnt=3 after 18 cycles from FREQ entry.
- Fetch ack delayed 4 cycles -> mem_req high 5 cycles, phase=0 throughout, phase[0] high exactly one cycle afterwards.
- mem_op=1 with MREQ ack after 2 cycles -> phase[3] single pulse following 3 zero cycles; instruction spans 9 cycles.
- halt_req pulsed during D -> finishes W, enters HALT, busy=0, instr_cnt+1; run=1 -> resumes at FREQ.
- TIMEOUT=3, mem_ack held 0 -> err=1 and ERR entered after 3 FREQ wait cycles; phase stays 0 until n_rst low; reset asserted mid-E clears all outputs asynchronously.
- PHASE_GEN_STEP_EN, step_mode=1 -> stalls in PAUSE after each W; each step pulse yields exactly one instruction (instr_cnt +1).
